if_id_skid_stage: RTL and testbench

// Parametrised IF->ID pipeline stage: registers fetched inst/pc/pc1/distinct and slices MIPS fields for the operator.

---
 rtl/if_id_skid_stage.sv | 159 +++++++++++++++
 tb/tb_if_id_skid_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_stage.sv
// IF->ID pipeline stage with a valid/ready handshake, a 2-entry skid buffer, flush and a
// saturating back-pressure counter. MIPS fields are sliced straight from the held word.
module if_id_skid_stage #(
   parameter int INST_MEM_WIDTH = 5,
   parameter int INST_WIDTH     = 32,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      CLK,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [INST_WIDTH-1:0]     inst,
   input  logic [INST_MEM_WIDTH-1:0] pc,
   input  logic [INST_MEM_WIDTH-1:0] pc1,
   input  logic                      distinct,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [INST_WIDTH-1:0]     out_inst,
   output logic [INST_MEM_WIDTH-1:0] out_pc,
   output logic [INST_MEM_WIDTH-1:0] out_pc1,
   output logic                      out_distinct,
   output logic [5:0]                opcode,
   output logic [5:0]                funct,
   output logic [4:0]                rs,
   output logic [4:0]                rt,
   output logic [4:0]                rd,
   output logic [4:0]                sa,
   output logic [15:0]               immediate,
   output logic [25:0]               inst_index,
   output logic [1:0]                occupancy,
   output logic [CNT_WIDTH-1:0]      stall_cycles
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [INST_WIDTH-1:0]     inst;
      logic [INST_MEM_WIDTH-1:0] pc;
      logic [INST_MEM_WIDTH-1:0] pc1;
      logic                      distinct;
   } entry_t;

   state_t                state_q, state_d;
   entry_t                main_q, main_d;
   entry_t                skid_q, skid_d;
   logic [CNT_WIDTH-1:0]  stall_q, stall_d;
   entry_t                in_entry;
   logic                  in_fire;
   logic                  out_fire;

   // in_ready looks only at registered state and reset, so no combinational path from out_ready.
   assign in_ready  = reset & (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_comb begin
      in_entry          = '0;
      in_entry.inst     = inst;
      in_entry.pc       = pc;
      in_entry.pc1      = pc1;
      in_entry.distinct = distinct;
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      stall_d = stall_q;

      unique case (state_q)
         EMPTY: begin
            if (in_fire) begin
               main_d  = in_entry;
               state_d = HALF;
            end
         end
         HALF: begin
            if (in_fire && out_fire) begin
               main_d = in_entry;
            end else if (in_fire) begin
               skid_d  = in_entry;
               state_d = FULL;
            end else if (out_fire) begin
               main_d  = '0;
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (out_fire) begin
               main_d  = skid_q;
               skid_d  = '0;
               state_d = HALF;
            end
         end
         default: begin
            main_d  = '0;
            skid_d  = '0;
            state_d = EMPTY;
         end
      endcase

      if (flush) begin
         main_d  = '0;
         skid_d  = '0;
         state_d = EMPTY;
      end

      if (out_valid && !out_ready && (stall_q != '1)) begin
         stall_d = stall_q + CNT_WIDTH'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge CLK) begin
      if (!reset) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         stall_q <= stall_d;
      end
   end

   always_comb begin
      unique case (state_q)
         EMPTY:   occupancy = 2'd0;
         HALF:    occupancy = 2'd1;
         FULL:    occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

   assign out_inst     = out_valid ? main_q.inst : '0;
   assign out_pc       = out_valid ? main_q.pc : '0;
   assign out_pc1      = out_valid ? main_q.pc1 : '0;
   assign out_distinct = out_valid & main_q.distinct;

   assign opcode       = out_inst[31:26];
   assign rs           = out_inst[25:21];
   assign rt           = out_inst[20:16];
   assign rd           = out_inst[15:11];
   assign sa           = out_inst[10:6];
   assign funct        = out_inst[5:0];
   assign immediate    = out_inst[15:0];
   assign inst_index   = out_inst[25:0];
   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Bench for if_id_skid_stage: directed steps then random traffic, compared each cycle
// against a queue-based reference model. A second instance uses a 3-bit stall counter.
module tb_if_id_skid_stage;

   logic        CLK;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic [31:0] inst;
   logic [4:0]  pc;
   logic [4:0]  pc1;
   logic        distinct;
   logic        out_ready;

   logic        in_ready, out_valid, out_distinct;
   logic [31:0] out_inst;
   logic [4:0]  out_pc, out_pc1, rs, rt, rd, sa;
   logic [5:0]  opcode, funct;
   logic [15:0] immediate;
   logic [25:0] inst_index;
   logic [1:0]  occupancy;
   logic [15:0] stall_cycles;

   logic        s_in_ready, s_out_valid, s_out_distinct;
   logic [31:0] s_out_inst;
   logic [4:0]  s_out_pc, s_out_pc1, s_rs, s_rt, s_rd, s_sa;
   logic [5:0]  s_opcode, s_funct;
   logic [15:0] s_immediate;
   logic [25:0] s_inst_index;
   logic [1:0]  s_occupancy;
   logic [2:0]  s_stall_cycles;

   if_id_skid_stage #(.INST_MEM_WIDTH(5), .INST_WIDTH(32), .CNT_WIDTH(16)) dut (
      .CLK(CLK), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .inst(inst), .pc(pc), .pc1(pc1), .distinct(distinct),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
      .out_pc(out_pc), .out_pc1(out_pc1), .out_distinct(out_distinct),
      .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .sa(sa),
      .immediate(immediate), .inst_index(inst_index),
      .occupancy(occupancy), .stall_cycles(stall_cycles)
   );

   if_id_skid_stage #(.INST_MEM_WIDTH(5), .INST_WIDTH(32), .CNT_WIDTH(3)) dut_sat (
      .CLK(CLK), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
      .inst(inst), .pc(pc), .pc1(pc1), .distinct(distinct),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_inst(s_out_inst),
      .out_pc(s_out_pc), .out_pc1(s_out_pc1), .out_distinct(s_out_distinct),
      .opcode(s_opcode), .funct(s_funct), .rs(s_rs), .rt(s_rt), .rd(s_rd), .sa(s_sa),
      .immediate(s_immediate), .inst_index(s_inst_index),
      .occupancy(s_occupancy), .stall_cycles(s_stall_cycles)
   );

   typedef struct {
      logic [31:0] inst;
      logic [4:0]  pc;
      logic [4:0]  pc1;
      logic        distinct;
   } ent_t;

   ent_t q[$];
   int   st16;
   int   st3;
   int   n_checks;
   int   n_errors;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected summary");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs();
      logic [31:0] ei;
      logic [4:0]  ep, ep1;
      logic        ed;
      ei = '0; ep = '0; ep1 = '0; ed = 1'b0;
      if (q.size() > 0) begin
         ei = q[0].inst; ep = q[0].pc; ep1 = q[0].pc1; ed = q[0].distinct;
      end
      check("out_valid",    32'(out_valid),    32'(q.size() > 0));
      check("occupancy",    32'(occupancy),    32'(q.size()));
      check("out_inst",     out_inst,          ei);
      check("out_pc",       32'(out_pc),       32'(ep));
      check("out_pc1",      32'(out_pc1),      32'(ep1));
      check("out_distinct", 32'(out_distinct), 32'(ed));
      check("opcode",       32'(opcode),       32'(ei[31:26]));
      check("rs",           32'(rs),           32'(ei[25:21]));
      check("rt",           32'(rt),           32'(ei[20:16]));
      check("rd",           32'(rd),           32'(ei[15:11]));
      check("sa",           32'(sa),           32'(ei[10:6]));
      check("funct",        32'(funct),        32'(ei[5:0]));
      check("immediate",    32'(immediate),    32'(ei[15:0]));
      check("inst_index",   32'(inst_index),   32'(ei[25:0]));
      check("stall_cycles", 32'(stall_cycles), 32'(st16));
      check("sat_stall",    32'(s_stall_cycles), 32'(st3));
      check("sat_occupancy", 32'(s_occupancy), 32'(q.size()));
      check("sat_out_inst", s_out_inst,        ei);
   endtask

   // One clock: check the handshake before the edge, advance the model at the edge, check after.
   task automatic tick();
      bit   m_ready, in_f, out_f, had;
      ent_t e;
      #1;
      m_ready = (reset === 1'b1) && (q.size() < 2);
      check("in_ready",     32'(in_ready),   32'(m_ready));
      check("sat_in_ready", 32'(s_in_ready), 32'(m_ready));
      had   = (q.size() > 0);
      in_f  = in_valid && m_ready;
      out_f = had && out_ready;
      e.inst = inst; e.pc = pc; e.pc1 = pc1; e.distinct = distinct;
      @(posedge CLK);
      if (reset !== 1'b1) begin
         q.delete();
         st16 = 0;
         st3  = 0;
      end else begin
         if (had && !out_ready) begin
            if (st16 < 65535) st16++;
            if (st3 < 7) st3++;
         end
         if (out_f) void'(q.pop_front());
         if (in_f) q.push_back(e);
         if (flush) q.delete();
      end
      #1;
      check_outputs();
   endtask

   task automatic set_word(input logic [31:0] w, input logic [4:0] p, input logic d);
      inst = w; pc = p; pc1 = p + 5'd1; distinct = d;
   endtask

   initial begin
      n_checks = 0; n_errors = 0; st16 = 0; st3 = 0;
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      set_word(32'h0, 5'd0, 1'b0);
      @(negedge CLK);

      // 1: reset for three cycles, then release
      for (int i = 0; i < 3; i++) tick();
      reset = 1'b1;
      tick();

      // 2: back-to-back stream with decode always ready
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         set_word(32'h8C010004 + 32'(i), 5'(i), i[0]);
         tick();
         if (i == 0) begin
            check("first_inst", out_inst, 32'h8C010004);
            check("first_rs", 32'(rs), 32'd0);
            check("first_rt", 32'(rt), 32'd1);
            check("first_imm", 32'(immediate), 32'd4);
         end
      end
      in_valid = 1'b0;
      tick();
      check("stream_drained", 32'(occupancy), 32'd0);

      // 3: back-pressure fills the skid, then drains in order
      out_ready = 1'b0;
      in_valid  = 1'b1;
      set_word(32'hAAAA0001, 5'd1, 1'b1); tick();
      set_word(32'hBBBB0002, 5'd2, 1'b0); tick();
      set_word(32'hCCCC0003, 5'd3, 1'b1); tick();
      check("bp_occupancy", 32'(occupancy), 32'd2);
      check("bp_head", out_inst, 32'hAAAA0001);
      tick();
      out_ready = 1'b1;
      tick();
      check("drain_b", out_inst, 32'hBBBB0002);
      tick();
      check("drain_c", out_inst, 32'hCCCC0003);
      in_valid = 1'b0;
      tick();
      check("drain_empty", 32'(out_valid), 32'd0);

      // 4: flush while full with a word on the input
      out_ready = 1'b0;
      in_valid  = 1'b1;
      set_word(32'h11110001, 5'd4, 1'b0); tick();
      set_word(32'h22220002, 5'd5, 1'b1); tick();
      set_word(32'h33330003, 5'd6, 1'b1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      check("flush_occ", 32'(occupancy), 32'd0);
      check("flush_inst", out_inst, 32'h0);
      tick();

      // 6: reset while full drops everything
      in_valid = 1'b1;
      set_word(32'h44440004, 5'd7, 1'b0); tick();
      set_word(32'h55550005, 5'd8, 1'b1); tick();
      in_valid = 1'b0;
      reset = 1'b0;
      tick();
      check("rst_occ", 32'(occupancy), 32'd0);
      check("rst_stall", 32'(stall_cycles), 32'd0);
      reset = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();

      // 5: long stall saturates the 3-bit counter
      out_ready = 1'b0;
      in_valid  = 1'b1;
      set_word(32'h66660006, 5'd9, 1'b0); tick();
      in_valid = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      check("sat_stop", 32'(s_stall_cycles), 32'd7);
      check("wide_count", 32'(stall_cycles), 32'd12);

      // random traffic: first half biased toward back-pressure
      for (int i = 0; i < 400; i++) begin
         reset     = ($urandom_range(0, 99) != 0);
         flush     = ($urandom_range(0, 24) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
         set_word($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
